// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter sharing one cached memory system between a
// data-memory requester (port 0) and an instruction-fetch requester (port 1).
// One request is captured at a time and driven to the memory system until
// mem_done. The reply is routed back to the granted port in the same cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   pN_rd, pN_wr              requests, held until pN_done
//   pN_addr, pN_data_in       request address / write data
//   pN_data_out, pN_done      read data and one-cycle completion pulse
//   pN_hit                    cache hit of the completing access (with done)
//   pN_stall                  request pending and not yet done
//   mem_rd, mem_wr            registered commands to the memory system
//   mem_addr, mem_data_in     registered address / write data to memory
//   mem_data_out, mem_done,
//   mem_stall, mem_hit        replies from the memory system
//   hit_cnt0, hit_cnt1        saturating per-port hit counters
//   err_illegal               sticky: a port presented rd and wr together
//   err_timeout               sticky: watchdog expired while BUSY
module mem_arbiter #(
   parameter int TIMEOUT = 32,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p0_rd,
   input  logic             p0_wr,
   input  logic [31:0]      p0_addr,
   input  logic [31:0]      p0_data_in,
   output logic [31:0]      p0_data_out,
   output logic             p0_done,
   output logic             p0_hit,
   output logic             p0_stall,
   input  logic             p1_rd,
   input  logic             p1_wr,
   input  logic [31:0]      p1_addr,
   input  logic [31:0]      p1_data_in,
   output logic [31:0]      p1_data_out,
   output logic             p1_done,
   output logic             p1_hit,
   output logic             p1_stall,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_data_in,
   input  logic [31:0]      mem_data_out,
   input  logic             mem_done,
   input  logic             mem_stall,
   input  logic             mem_hit,
   output logic [CNT_W-1:0] hit_cnt0,
   output logic [CNT_W-1:0] hit_cnt1,
   output logic             err_illegal,
   output logic             err_timeout
);

   localparam int WDOG_W = $clog2(TIMEOUT + 1);
   localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
   localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_n_s;
   logic              grant_r;       // port owning the in-flight access
   logic              last_grant_r;  // port granted most recently
   logic [WDOG_W-1:0] wdog_r;
   logic              mem_rd_r;
   logic              mem_wr_r;
   logic [31:0]       mem_addr_r;
   logic [31:0]       mem_data_in_r;
   logic [CNT_W-1:0]  hit_cnt0_r;
   logic [CNT_W-1:0]  hit_cnt1_r;
   logic              err_illegal_r;
   logic              err_timeout_r;

   logic              elig0_s;
   logic              elig1_s;
   logic              illegal_s;
   logic              grant_vld_s;
   logic              grant_sel_s;
   logic              reply_s;

   // A port is eligible only with exactly one of rd/wr; both high is illegal.
   always_comb begin
      elig0_s   = p0_rd ^ p0_wr;
      elig1_s   = p1_rd ^ p1_wr;
      illegal_s = (p0_rd & p0_wr) | (p1_rd & p1_wr);
      reply_s   = (state_r == ST_BUSY) & mem_done;
   end

   // Next-state and grant selection; on contention the port not granted last wins.
   always_comb begin
      state_n_s   = state_r;
      grant_vld_s = 1'b0;
      grant_sel_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (mem_stall) begin
               grant_vld_s = 1'b0;
            end else if (elig0_s && elig1_s) begin
               grant_vld_s = 1'b1;
               grant_sel_s = ~last_grant_r;
            end else if (elig0_s) begin
               grant_vld_s = 1'b1;
               grant_sel_s = 1'b0;
            end else if (elig1_s) begin
               grant_vld_s = 1'b1;
               grant_sel_s = 1'b1;
            end else begin
               grant_vld_s = 1'b0;
            end
            if (grant_vld_s) begin
               state_n_s = ST_BUSY;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mem_done) begin
               state_n_s = ST_IDLE;
            end else begin
               state_n_s = ST_BUSY;
            end
         end
         default: begin
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // State register and grant bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
      end else begin
         state_r <= state_n_s;
         if (grant_vld_s) begin
            grant_r      <= grant_sel_s;
            last_grant_r <= grant_sel_s;
         end
      end
   end

   // Memory command registers: captured on grant, held while BUSY, dropped on done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_rd_r      <= 1'b0;
         mem_wr_r      <= 1'b0;
         mem_addr_r    <= 32'h0000_0000;
         mem_data_in_r <= 32'h0000_0000;
      end else if (grant_vld_s) begin
         mem_rd_r      <= grant_sel_s ? p1_rd      : p0_rd;
         mem_wr_r      <= grant_sel_s ? p1_wr      : p0_wr;
         mem_addr_r    <= grant_sel_s ? p1_addr    : p0_addr;
         mem_data_in_r <= grant_sel_s ? p1_data_in : p0_data_in;
      end else if (reply_s) begin
         mem_rd_r <= 1'b0;
         mem_wr_r <= 1'b0;
      end
   end

   // Watchdog counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wdog_r        <= {WDOG_W{1'b0}};
         err_timeout_r <= 1'b0;
      end else if (grant_vld_s) begin
         wdog_r <= {WDOG_W{1'b0}};
      end else if ((state_r == ST_BUSY) && !mem_done) begin
         if (wdog_r != WDOG_MAX) begin
            wdog_r <= wdog_r + WDOG_ONE;
         end
         if (wdog_r == WDOG_LAST) begin
            err_timeout_r <= 1'b1;
         end
      end
   end

   // Saturating per-port hit counters, stepped on a completing hit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_cnt0_r <= {CNT_W{1'b0}};
         hit_cnt1_r <= {CNT_W{1'b0}};
      end else if (reply_s && mem_hit) begin
         if (!grant_r && (hit_cnt0_r != CNT_MAX)) begin
            hit_cnt0_r <= hit_cnt0_r + CNT_ONE;
         end
         if (grant_r && (hit_cnt1_r != CNT_MAX)) begin
            hit_cnt1_r <= hit_cnt1_r + CNT_ONE;
         end
      end
   end

   // Sticky illegal-request flag, sampled only while IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_illegal_r <= 1'b0;
      end else if ((state_r == ST_IDLE) && illegal_s) begin
         err_illegal_r <= 1'b1;
      end
   end

   // Zero-latency reply routing to the granted port; the other port sees zeros.
   always_comb begin
      p0_done     = reply_s & ~grant_r;
      p1_done     = reply_s &  grant_r;
      p0_hit      = p0_done & mem_hit;
      p1_hit      = p1_done & mem_hit;
      p0_data_out = p0_done ? mem_data_out : 32'h0000_0000;
      p1_data_out = p1_done ? mem_data_out : 32'h0000_0000;
      p0_stall    = (p0_rd | p0_wr) & ~p0_done;
      p1_stall    = (p1_rd | p1_wr) & ~p1_done;
   end

   assign mem_rd      = mem_rd_r;
   assign mem_wr      = mem_wr_r;
   assign mem_addr    = mem_addr_r;
   assign mem_data_in = mem_data_in_r;
   assign hit_cnt0    = hit_cnt0_r;
   assign hit_cnt1    = hit_cnt1_r;
   assign err_illegal = err_illegal_r;
   assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change 1ns after the
// rising edge; outputs are checked 1ns after that, well before the next edge.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        p0_rd, p0_wr, p1_rd, p1_wr;
   logic [31:0] p0_addr, p0_data_in, p1_addr, p1_data_in;
   logic [31:0] p0_data_out, p1_data_out;
   logic        p0_done, p1_done, p0_hit, p1_hit, p0_stall, p1_stall;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_addr, mem_data_in, mem_data_out;
   logic        mem_done, mem_stall, mem_hit;
   logic [15:0] hit_cnt0, hit_cnt1;
   logic        err_illegal, err_timeout;

   int checks = 0;
   int errors = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_data_in(p0_data_in),
      .p0_data_out(p0_data_out), .p0_done(p0_done), .p0_hit(p0_hit), .p0_stall(p0_stall),
      .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_data_in(p1_data_in),
      .p1_data_out(p1_data_out), .p1_done(p1_done), .p1_hit(p1_hit), .p1_stall(p1_stall),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
      .hit_cnt0(hit_cnt0), .hit_cnt1(hit_cnt1),
      .err_illegal(err_illegal), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after input changes.
   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b0;
      p0_rd = 1'b0; p0_wr = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
      p0_addr = 32'h0; p0_data_in = 32'h0; p1_addr = 32'h0; p1_data_in = 32'h0;
      mem_data_out = 32'h0; mem_done = 1'b0; mem_stall = 1'b0; mem_hit = 1'b0;
      step(); step();
      settle();
      check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_hit_cnt0", {16'd0, hit_cnt0}, 32'd0);
      check("rst_err", {30'd0, err_illegal, err_timeout}, 32'd0);
      rst = 1'b1;
      step();

      // ---- single read on port 0 ----
      p0_rd = 1'b1; p0_addr = 32'h0000_0010;
      settle();
      check("rd_stall_pending", {31'd0, p0_stall}, 32'd1);
      check("rd_no_issue_yet", {31'd0, mem_rd}, 32'd0);
      step();
      check("rd_issue", {31'd0, mem_rd}, 32'd1);
      check("rd_addr", mem_addr, 32'h0000_0010);
      check("rd_not_done", {31'd0, p0_done}, 32'd0);
      step();
      mem_done = 1'b1; mem_hit = 1'b1; mem_data_out = 32'hDEAD_BEEF;
      settle();
      check("rd_done", {31'd0, p0_done}, 32'd1);
      check("rd_data", p0_data_out, 32'hDEAD_BEEF);
      check("rd_hit", {31'd0, p0_hit}, 32'd1);
      check("rd_stall_clear", {31'd0, p0_stall}, 32'd0);
      check("rd_p1_data_zero", p1_data_out, 32'd0);
      step();
      mem_done = 1'b0; mem_hit = 1'b0; p0_rd = 1'b0;
      settle();
      check("rd_drop_cmd", {31'd0, mem_rd}, 32'd0);
      check("rd_hit_cnt0", {16'd0, hit_cnt0}, 32'd1);
      // mem_done while IDLE is ignored
      mem_done = 1'b1;
      settle();
      check("idle_done_ignored", {30'd0, p1_done, p0_done}, 32'd0);
      step();
      mem_done = 1'b0;

      // ---- contention after reset: order 0,1,0,1 ----
      rst = 1'b0;
      step();
      rst = 1'b1;
      p0_rd = 1'b1; p0_addr = 32'h0000_0A00;
      p1_rd = 1'b1; p1_addr = 32'h0000_0B00;
      settle();
      check("cont_both_stall", {30'd0, p1_stall, p0_stall}, 32'd3);
      for (int i = 0; i < 4; i++) begin
         logic        g;
         logic [31:0] exp_addr;
         g = i[0];
         exp_addr = g ? 32'h0000_0B00 : 32'h0000_0A00;
         step();
         check("cont_issue", {31'd0, mem_rd}, 32'd1);
         check("cont_addr", mem_addr, exp_addr);
         mem_done = 1'b1; mem_hit = g; mem_data_out = 32'h1000_0000 + i;
         settle();
         check("cont_done", {30'd0, p1_done, p0_done}, g ? 32'd2 : 32'd1);
         check("cont_data", g ? p1_data_out : p0_data_out, 32'h1000_0000 + i);
         step();
         mem_done = 1'b0; mem_hit = 1'b0;
         settle();
         check("cont_gap", {31'd0, mem_rd}, 32'd0);
      end
      check("cont_hit_cnt0", {16'd0, hit_cnt0}, 32'd0);
      check("cont_hit_cnt1", {16'd0, hit_cnt1}, 32'd2);
      p0_rd = 1'b0; p1_rd = 1'b0;
      step();

      // ---- write on port 1 ----
      p1_wr = 1'b1; p1_addr = 32'h0000_0200; p1_data_in = 32'h1234_5678;
      step();
      p1_addr = 32'h0000_FFFF; p1_data_in = 32'h0;
      settle();
      check("wr_issue", {30'd0, mem_rd, mem_wr}, 32'd1);
      check("wr_addr", mem_addr, 32'h0000_0200);
      check("wr_data", mem_data_in, 32'h1234_5678);
      check("wr_stall", {31'd0, p1_stall}, 32'd1);
      step();
      check("wr_hold_addr", mem_addr, 32'h0000_0200);
      check("wr_hold_wr", {31'd0, mem_wr}, 32'd1);
      check("wr_p0_quiet", {31'd0, p0_done}, 32'd0);
      step();
      mem_done = 1'b1;
      settle();
      check("wr_done", {30'd0, p1_done, p0_done}, 32'd2);
      check("wr_stall_clear", {31'd0, p1_stall}, 32'd0);
      step();
      mem_done = 1'b0; p1_wr = 1'b0;
      settle();
      check("wr_drop", {31'd0, mem_wr}, 32'd0);

      // ---- memory busy: no grant while mem_stall ----
      mem_stall = 1'b1; p0_rd = 1'b1; p0_addr = 32'h0000_0040;
      for (int i = 0; i < 6; i++) begin
         step();
         check("stall_no_issue", {31'd0, mem_rd}, 32'd0);
      end
      mem_stall = 1'b0;
      step();
      check("stall_issue", {31'd0, mem_rd}, 32'd1);
      check("stall_addr", mem_addr, 32'h0000_0040);
      mem_done = 1'b1;
      step();
      mem_done = 1'b0; p0_rd = 1'b0;

      // ---- watchdog ----
      p0_rd = 1'b1; p0_addr = 32'h0000_0080;
      step();
      for (int k = 1; k <= 40; k++) begin
         check("wdog_flag", {31'd0, err_timeout}, (k >= 33) ? 32'd1 : 32'd0);
         check("wdog_busy", {31'd0, mem_rd}, 32'd1);
         step();
      end
      mem_done = 1'b1;
      step();
      mem_done = 1'b0; p0_rd = 1'b0;
      settle();
      check("wdog_sticky", {31'd0, err_timeout}, 32'd1);

      // ---- illegal request on port 1, legal on port 0 ----
      p1_rd = 1'b1; p1_wr = 1'b1; p1_addr = 32'h0000_0300;
      p0_rd = 1'b1; p0_addr = 32'h0000_0400;
      settle();
      check("ill_not_yet", {31'd0, err_illegal}, 32'd0);
      step();
      check("ill_set", {31'd0, err_illegal}, 32'd1);
      check("ill_grant_p0", mem_addr, 32'h0000_0400);
      check("ill_cmd", {30'd0, mem_rd, mem_wr}, 32'd2);
      mem_done = 1'b1;
      settle();
      check("ill_p0_done", {30'd0, p1_done, p0_done}, 32'd1);
      step();
      mem_done = 1'b0; p0_rd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ill_never_p1", {30'd0, mem_rd, mem_wr}, 32'd0);
      end
      p1_rd = 1'b0; p1_wr = 1'b0;
      check("ill_sticky", {31'd0, err_illegal}, 32'd1);

      // ---- reset mid-transaction ----
      step();
      p0_rd = 1'b1; p0_addr = 32'h0000_0500;
      step();
      step();
      step();
      check("mid_busy", {31'd0, mem_rd}, 32'd1);
      rst = 1'b0; p0_rd = 1'b0;
      step();
      rst = 1'b1;
      mem_done = 1'b1; mem_hit = 1'b1;
      settle();
      check("mid_rd_dropped", {31'd0, mem_rd}, 32'd0);
      check("mid_no_done", {30'd0, p1_done, p0_done}, 32'd0);
      step();
      mem_done = 1'b0; mem_hit = 1'b0;
      settle();
      check("mid_cnts", {hit_cnt1, hit_cnt0}, 32'd0);
      check("mid_errs", {30'd0, err_illegal, err_timeout}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single cached memory system (`mem_system_hier` Rd/Wr/Done/Stall/CacheHit handshake) between a data-memory requester (port 0) and an instruction-fetch requester (port 1). It sits between the pipeline's memory stages and the cache. It captures one request at a time and drives it to the memory system until `Done`. It routes the reply back to the granted port and keeps per-port hit statistics plus a latency watchdog.

## Interface
- `TIMEOUT`, default 32: BUSY cycles without `mem_done` before `err_timeout` sets.
- `CNT_W`, default 16: width of the per-port hit counters.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `p0_rd`, `p0_wr`, `p1_rd`, `p1_wr` in 1 each: requests. Held by the requester until its `pN_done`.
- `p0_addr`, `p1_addr` in 32: request addresses.
- `p0_data_in`, `p1_data_in` in 32: write data.
- `p0_data_out`, `p1_data_out` out 32: read data. Valid when the port's `done` is high.
- `p0_done`, `p1_done` out 1: one-cycle completion pulse.
- `p0_hit`, `p1_hit` out 1: `CacheHit` of the completing access. Qualified by the port's `done`.
- `p0_stall`, `p1_stall` out 1: request pending and not yet done.
- `mem_rd`, `mem_wr` out 1: to the memory system. Registered.
- `mem_addr`, `mem_data_in` out 32: to the memory system. Registered.
- `mem_data_out` in 32, `mem_done` in 1, `mem_stall` in 1, `mem_hit` in 1: from the memory system.
- `hit_cnt0`, `hit_cnt1` out `CNT_W`: saturating hit counters.
- `err_illegal` out 1: sticky. Set when a port presents rd and wr together.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- States: IDLE and BUSY.
- IDLE:
  - If `mem_stall` is 1, no grant is made.
  - Otherwise the eligible ports are those with exactly one of rd/wr high.
  - Both eligible: grant the port that differs from `last_grant`.
  - One eligible: grant that port.
  - On a grant, at the edge: register `mem_rd`/`mem_wr`/`mem_addr`/`mem_data_in` from the granted port, set `grant`, set `last_grant` to the granted port, clear `wdog`, go to BUSY.
- Illegal request (a port with rd and wr both high while IDLE): that port is never granted. `err_illegal` sets at the next edge and stays set until reset.
- BUSY:
  - `mem_*` outputs hold their captured values. Later changes on the requester's inputs are ignored.
  - While `mem_done` is 0: `wdog` increments, saturating at `TIMEOUT`. When `wdog` reaches `TIMEOUT - 1` and `mem_done` is still 0, `err_timeout` sets at that edge. The block stays in BUSY.
  - When `mem_done` is 1 (combinational, same cycle): `pG_done = 1`, `pG_data_out = mem_data_out`, `pG_hit = mem_hit`, where G = `grant`.
  - At that edge: `mem_rd`/`mem_wr` go to 0, state goes to IDLE, and `hit_cntG` increments if `mem_hit` is 1 (saturating at all-ones).
- Non-granted port: `done` = 0, `hit` = 0, `data_out` = 0.
- `pN_stall` = (`pN_rd` | `pN_wr`) & !`pN_done`.
- A requester may drop an un-granted request at any time. Nothing is captured in that case.
- Reset values:
  - state IDLE, `last_grant` = 1 (port 0 favoured first).
  - `mem_rd`, `mem_wr` = 0; `mem_addr`, `mem_data_in` = 0.
  - counters 0, `wdog` 0, `err_illegal` 0, `err_timeout` 0.
  - All combinational outputs follow from this state.
- Reset while BUSY: `mem_rd`/`mem_wr` drop at that edge and the in-flight reply is discarded. A `mem_done` arriving after reset is ignored because the state is IDLE.

## Timing
- Request seen in IDLE at cycle N with `mem_stall` = 0 → `mem_rd`/`mem_wr` high from cycle N+1.
- Memory `Done` at cycle M → `pG_done` in cycle M (zero added latency on the reply).
- Next grant is decided in cycle M+1. Its `mem_rd`/`mem_wr` are high from cycle M+2.
- Back-to-back requests have one dead cycle between them on the `mem_*` bus.
- Arbiter overhead is 1 cycle on the request path. A cache hit completing 1 cycle after issue shows as a 2-cycle port latency.
- `mem_done` while IDLE is ignored and produces no port `done`.

## Test plan
- Single read: `p0_rd` = 1, `p0_addr` = 0x0010 at cycle 5 → `mem_rd` = 1 with `mem_addr` = 0x0010 at cycle 6. Memory model returns 0xDEADBEEF with `mem_done` and `mem_hit` = 1 at cycle 7 → `p0_done` = 1, `p0_data_out` = 0xDEADBEEF, `p0_hit` = 1 at cycle 7; `hit_cnt0` = 1 at cycle 8.
- Contention after reset: both ports read at cycle 3 → port 0 granted first; port 1 is issued two cycles after port 0's `done`. Both ports then re-request continuously for 4 transactions → grant order 0,1,0,1.
- Write on port 1: `p1_wr` = 1, addr 0x0200, data 0x12345678 → `mem_wr` = 1 with the same addr/data, held until `mem_done`. `p1_stall` is high until `p1_done`, and `p0_done` stays 0 throughout.
- Memory busy: `mem_stall` = 1 for cycles 4-9 with `p0_rd` high from cycle 4 → no `mem_rd` before cycle 11. The request issues normally afterwards.
- Watchdog and illegal request: hold `mem_done` low for 40 cycles → `err_timeout` sets after 32 BUSY cycles and stays set. Separately, drive `p1_rd` = `p1_wr` = 1 → `err_illegal` sets and port 1 is never granted.
- Reset mid-transaction: assert `rst` = 0 at BUSY cycle 3, then pulse `mem_done` → `mem_rd` = 0 after the reset edge, no port `done`, all counters 0.
